// File: rtl/unidade_controle_jogo.sv
// -----------------------------------------------------------------------------
// unidade_controle_jogo
//   Moore control unit for the memory game. It sequences showing the stored
//   pattern, taking and comparing player presses, extending the sequence by
//   writing a new entry at the end of each round, and reporting how the game
//   ended (win, wrong press, inactivity timeout).
//
// Ports
//   clock              rising-edge system clock
//   reset              synchronous, active-high; returns to inicial
//   iniciar            start / restart request (level)
//   jogada_feita       a press was detected (single-cycle pulse)
//   jogada_igual       the registered press matches memory
//   fim_rodada         last play of the current round
//   fim_jogo           last round of the game
//   fim_mostra_led     LED display interval elapsed
//   inativo            inactivity timeout
//   zera_* / conta_*   clear / increment controls for datapath counters
//   zeraR / registraR  clear / load of the press register
//   zeraInativo / contaInativo  inactivity counter controls
//   ramWE              pattern memory write enable
//   mostra_led         show memory value at the current address
//   pronto, acertou, errou, timeout  game-end status
//   db_estado          current state code
// -----------------------------------------------------------------------------
module unidade_controle_jogo (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       jogada_igual,
  input  logic       fim_rodada,
  input  logic       fim_jogo,
  input  logic       fim_mostra_led,
  input  logic       inativo,
  output logic       zera_jogada,
  output logic       conta_jogada,
  output logic       zera_rodada,
  output logic       conta_rodada,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraInativo,
  output logic       contaInativo,
  output logic       zera_mostra_led,
  output logic       conta_mostra_led,
  output logic       ramWE,
  output logic       mostra_led,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL          = 4'h0,
    PREPARACAO       = 4'h1,
    INICIA_RODADA    = 4'h2,
    MOSTRA           = 4'h3,
    ESPERA_JOGADA    = 4'h4,
    REGISTRA         = 4'h5,
    COMPARA          = 4'h6,
    PROXIMA_JOGADA   = 4'h7,
    AVANCA_ESCRITA   = 4'h8,
    ESPERA_ESCRITA   = 4'h9,
    REGISTRA_ESCRITA = 4'hA,
    ESCREVE          = 4'hB,
    PROXIMA_RODADA   = 4'hC,
    FIM_ACERTOU      = 4'hD,
    FIM_ERROU        = 4'hE,
    FIM_TIMEOUT      = 4'hF
  } state_t;

  typedef struct packed {
    logic zera_jogada;
    logic conta_jogada;
    logic zera_rodada;
    logic conta_rodada;
    logic zeraR;
    logic registraR;
    logic zeraInativo;
    logic contaInativo;
    logic zera_mostra_led;
    logic conta_mostra_led;
    logic ramWE;
    logic mostra_led;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q;

  // Output decode for a given state. It is applied to the next state and
  // registered, so the registered outputs always belong to state_q while
  // staying glitch-free and independent of the current inputs.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      PREPARACAO: begin
        c.zera_jogada     = 1'b1;
        c.zera_rodada     = 1'b1;
        c.zeraR           = 1'b1;
        c.zeraInativo     = 1'b1;
        c.zera_mostra_led = 1'b1;
      end
      INICIA_RODADA: begin
        c.zera_jogada     = 1'b1;
        c.zeraInativo     = 1'b1;
        c.zera_mostra_led = 1'b1;
      end
      MOSTRA: begin
        c.mostra_led       = 1'b1;
        c.conta_mostra_led = 1'b1;
        c.zeraInativo      = 1'b1;
      end
      ESPERA_JOGADA, ESPERA_ESCRITA: begin
        c.contaInativo = 1'b1;
      end
      REGISTRA, REGISTRA_ESCRITA: begin
        c.registraR   = 1'b1;
        c.zeraInativo = 1'b1;
      end
      PROXIMA_JOGADA, AVANCA_ESCRITA: begin
        c.conta_jogada = 1'b1;
        c.zeraInativo  = 1'b1;
      end
      ESCREVE:        c.ramWE        = 1'b1;
      PROXIMA_RODADA: c.conta_rodada = 1'b1;
      FIM_ACERTOU: begin
        c.pronto  = 1'b1;
        c.acertou = 1'b1;
      end
      FIM_ERROU: begin
        c.pronto = 1'b1;
        c.errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        c.pronto  = 1'b1;
        c.timeout = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:          if (iniciar) state_d = PREPARACAO;
      PREPARACAO:       state_d = INICIA_RODADA;
      INICIA_RODADA:    state_d = MOSTRA;
      MOSTRA:           if (fim_mostra_led) state_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jogada_feita)  state_d = REGISTRA;
        else if (inativo)  state_d = FIM_TIMEOUT;
      end
      REGISTRA:         state_d = COMPARA;
      COMPARA: begin
        if (!jogada_igual)             state_d = FIM_ERROU;
        else if (fim_rodada && fim_jogo) state_d = FIM_ACERTOU;
        else if (fim_rodada)           state_d = AVANCA_ESCRITA;
        else                           state_d = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA:   state_d = ESPERA_JOGADA;
      AVANCA_ESCRITA:   state_d = ESPERA_ESCRITA;
      ESPERA_ESCRITA: begin
        if (jogada_feita)  state_d = REGISTRA_ESCRITA;
        else if (inativo)  state_d = FIM_TIMEOUT;
      end
      REGISTRA_ESCRITA: state_d = ESCREVE;
      ESCREVE:          state_d = PROXIMA_RODADA;
      PROXIMA_RODADA:   state_d = INICIA_RODADA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                        if (iniciar) state_d = PREPARACAO;
      default:          state_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INICIAL;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
    end
  end

  assign zera_jogada      = ctrl_q.zera_jogada;
  assign conta_jogada     = ctrl_q.conta_jogada;
  assign zera_rodada      = ctrl_q.zera_rodada;
  assign conta_rodada     = ctrl_q.conta_rodada;
  assign zeraR            = ctrl_q.zeraR;
  assign registraR        = ctrl_q.registraR;
  assign zeraInativo      = ctrl_q.zeraInativo;
  assign contaInativo     = ctrl_q.contaInativo;
  assign zera_mostra_led  = ctrl_q.zera_mostra_led;
  assign conta_mostra_led = ctrl_q.conta_mostra_led;
  assign ramWE            = ctrl_q.ramWE;
  assign mostra_led       = ctrl_q.mostra_led;
  assign pronto           = ctrl_q.pronto;
  assign acertou          = ctrl_q.acertou;
  assign errou            = ctrl_q.errou;
  assign timeout          = ctrl_q.timeout;
  assign db_estado        = state_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// -----------------------------------------------------------------------------
// tb_unidade_controle_jogo
//   Directed bench for the game control unit: walks the state graph through
//   show, play, round advance with memory write, win, wrong press, timeout,
//   input priority and reset during a write.
// -----------------------------------------------------------------------------
module tb_unidade_controle_jogo;

  logic       clock = 1'b0;
  logic       reset, iniciar, jogada_feita, jogada_igual;
  logic       fim_rodada, fim_jogo, fim_mostra_led, inativo;
  logic       zera_jogada, conta_jogada, zera_rodada, conta_rodada;
  logic       zeraR, registraR, zeraInativo, contaInativo;
  logic       zera_mostra_led, conta_mostra_led, ramWE, mostra_led;
  logic       pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;

  unidade_controle_jogo dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .jogada_feita(jogada_feita), .jogada_igual(jogada_igual),
    .fim_rodada(fim_rodada), .fim_jogo(fim_jogo),
    .fim_mostra_led(fim_mostra_led), .inativo(inativo),
    .zera_jogada(zera_jogada), .conta_jogada(conta_jogada),
    .zera_rodada(zera_rodada), .conta_rodada(conta_rodada),
    .zeraR(zeraR), .registraR(registraR),
    .zeraInativo(zeraInativo), .contaInativo(contaInativo),
    .zera_mostra_led(zera_mostra_led), .conta_mostra_led(conta_mostra_led),
    .ramWE(ramWE), .mostra_led(mostra_led),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Bit order: zera_jogada conta_jogada zera_rodada conta_rodada zeraR
  // registraR zeraInativo contaInativo zera_mostra_led conta_mostra_led
  // ramWE mostra_led pronto acertou errou timeout
  function automatic logic [15:0] exp_out(input logic [3:0] s);
    case (s)
      4'h1:    return 16'b1010_1010_1000_0000; // preparacao
      4'h2:    return 16'b1000_0010_1000_0000; // inicia_rodada
      4'h3:    return 16'b0000_0010_0101_0000; // mostra
      4'h4:    return 16'b0000_0001_0000_0000; // espera_jogada
      4'h5:    return 16'b0000_0110_0000_0000; // registra
      4'h7:    return 16'b0100_0010_0000_0000; // proxima_jogada
      4'h8:    return 16'b0100_0010_0000_0000; // avanca_escrita
      4'h9:    return 16'b0000_0001_0000_0000; // espera_escrita
      4'hA:    return 16'b0000_0110_0000_0000; // registra_escrita
      4'hB:    return 16'b0000_0000_0010_0000; // escreve
      4'hC:    return 16'b0001_0000_0000_0000; // proxima_rodada
      4'hD:    return 16'b0000_0000_0000_1100; // fim_acertou
      4'hE:    return 16'b0000_0000_0000_1010; // fim_errou
      4'hF:    return 16'b0000_0000_0000_1001; // fim_timeout
      default: return 16'h0000;                // inicial, compara
    endcase
  endfunction

  function automatic logic [15:0] outs();
    return {zera_jogada, conta_jogada, zera_rodada, conta_rodada, zeraR,
            registraR, zeraInativo, contaInativo, zera_mostra_led,
            conta_mostra_led, ramWE, mostra_led, pronto, acertou, errou,
            timeout};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock edge, then check state code and full output vector.
  task automatic step(input string tag, input logic [3:0] s);
    @(posedge clock);
    #1;
    chk({tag, ".estado"}, {12'h0, db_estado}, {12'h0, s});
    chk({tag, ".saidas"}, outs(), exp_out(s));
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; jogada_feita = 1'b0; jogada_igual = 1'b0;
    fim_rodada = 1'b0; fim_jogo = 1'b0; fim_mostra_led = 1'b0; inativo = 1'b0;

    step("reset", 4'h0);
    reset = 1'b0;
    step("idle", 4'h0);

    // Start, show phase waits for fim_mostra_led
    iniciar = 1'b1;
    step("start", 4'h1);
    iniciar = 1'b0;
    step("inicia", 4'h2);
    step("mostra", 4'h3);
    step("mostra_hold", 4'h3);
    fim_mostra_led = 1'b1;
    step("espera", 4'h4);

    // Idle in espera; iniciar is ignored here
    iniciar = 1'b1;
    step("espera_hold", 4'h4);
    iniciar = 1'b0;

    // Matching press mid-round: 5,6,7,4
    jogada_feita = 1'b1; jogada_igual = 1'b1;
    step("registra", 4'h5);
    jogada_feita = 1'b0;
    step("compara", 4'h6);
    step("prox_jogada", 4'h7);
    step("espera2", 4'h4);

    // Last play of the round: 5,6,8,9,A,B,C,2
    jogada_feita = 1'b1;
    step("registra2", 4'h5);
    jogada_feita = 1'b0; fim_rodada = 1'b1;
    step("compara2", 4'h6);
    step("avanca", 4'h8);
    fim_rodada = 1'b0;
    step("esp_escr", 4'h9);
    step("esp_escr_hold", 4'h9);
    jogada_feita = 1'b1; inativo = 1'b1;   // press wins over timeout
    step("reg_escr", 4'hA);
    jogada_feita = 1'b0; inativo = 1'b0;
    step("escreve", 4'hB);
    step("prox_rodada", 4'hC);
    step("inicia2", 4'h2);
    step("mostra2", 4'h3);
    step("espera3", 4'h4);

    // Wrong press, with simultaneous inactivity: press still wins
    jogada_feita = 1'b1; inativo = 1'b1; jogada_igual = 1'b0;
    step("registra3", 4'h5);
    jogada_feita = 1'b0; inativo = 1'b0;
    step("compara3", 4'h6);
    step("errou", 4'hE);
    step("errou_hold", 4'hE);
    iniciar = 1'b1;
    step("restart1", 4'h1);
    iniciar = 1'b0;
    step("inicia4", 4'h2);
    step("mostra4", 4'h3);
    step("espera4", 4'h4);

    // Win: match on last play of last round
    jogada_feita = 1'b1; jogada_igual = 1'b1;
    step("registra4", 4'h5);
    jogada_feita = 1'b0; fim_rodada = 1'b1; fim_jogo = 1'b1;
    step("compara4", 4'h6);
    step("acertou", 4'hD);
    fim_rodada = 1'b0; fim_jogo = 1'b0;
    step("acertou_hold", 4'hD);
    iniciar = 1'b1;
    step("restart2", 4'h1);
    iniciar = 1'b0;
    step("inicia5", 4'h2);
    step("mostra5", 4'h3);
    step("espera5", 4'h4);

    // Timeout in espera_escrita
    jogada_feita = 1'b1;
    step("registra5", 4'h5);
    jogada_feita = 1'b0; fim_rodada = 1'b1;
    step("compara5", 4'h6);
    step("avanca5", 4'h8);
    fim_rodada = 1'b0;
    step("esp_escr5", 4'h9);
    inativo = 1'b1;
    step("timeout", 4'hF);
    inativo = 1'b0;
    step("timeout_hold", 4'hF);
    iniciar = 1'b1;
    step("restart3", 4'h1);
    iniciar = 1'b0;
    step("inicia6", 4'h2);
    step("mostra6", 4'h3);
    step("espera6", 4'h4);

    // Reset while writing
    jogada_feita = 1'b1;
    step("registra6", 4'h5);
    jogada_feita = 1'b0; fim_rodada = 1'b1;
    step("compara6", 4'h6);
    step("avanca6", 4'h8);
    fim_rodada = 1'b0;
    step("esp_escr6", 4'h9);
    jogada_feita = 1'b1;
    step("reg_escr6", 4'hA);
    jogada_feita = 1'b0;
    step("escreve6", 4'hB);
    reset = 1'b1;
    step("reset_escreve", 4'h0);
    reset = 1'b0;
    step("after_reset", 4'h0);
    chk("ramWE_after_reset", {15'h0, ramWE}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
